// File: rtl/scan_priority_encoder.sv
// Captures a request vector and streams the indices of its set bits, one beat per
// accepted output handshake, in lowest-first or highest-first order.
module scan_priority_encoder #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = $clog2(WIDTH),
    localparam int CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_none,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_capture;
    logic             w_advance;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_clr_mask;
    logic [WIDTH-1:0] w_next_pend;
    logic [WIDTH-1:0] w_scan_src;
    logic [IDX_W-1:0] w_scan_idx;
    logic [CNT_W-1:0] w_scan_cnt;
    logic             w_scan_last;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_last;
    logic             r_out_none;
    logic [CNT_W-1:0] r_out_count;

    function automatic logic [CNT_W-1:0] f_popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // Priority scan: first set bit met in the configured direction wins.
    function automatic logic [IDX_W-1:0] f_scan_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            int b;
            b = MSB_FIRST ? (WIDTH - 1 - i) : i;
            if (!found && v[b]) begin
                idx   = IDX_W'(b);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    w_advance   = 1'b1;
                    w_state_nxt = r_out_last ? ST_IDLE : ST_EMIT;
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Scan either the incoming vector (capture) or pending minus the bit being retired.
    always_comb begin
        w_clr_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_clr_mask[i] = (r_out_idx == IDX_W'(i));
        end
        w_next_pend = r_pending & ~w_clr_mask;
        if (r_state == ST_IDLE) begin
            w_scan_src = in_vec;
        end else begin
            w_scan_src = w_next_pend;
        end
        w_scan_idx  = f_scan_idx(w_scan_src);
        w_scan_cnt  = f_popcount(w_scan_src);
        w_scan_last = (w_scan_cnt <= CNT_W'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending vector and registered beat fields; cleared when the final beat retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_none  <= 1'b0;
            r_out_count <= '0;
        end else if (w_capture) begin
            r_pending   <= in_vec;
            r_out_idx   <= w_scan_idx;
            r_out_last  <= w_scan_last;
            r_out_none  <= (w_scan_cnt == CNT_W'(0));
            r_out_count <= w_scan_cnt;
        end else if (w_advance && r_out_last) begin
            r_pending   <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_none  <= 1'b0;
            r_out_count <= '0;
        end else if (w_advance) begin
            r_pending   <= w_next_pend;
            r_out_idx   <= w_scan_idx;
            r_out_last  <= w_scan_last;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_EMIT);
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign out_none  = r_out_none;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_scan_priority_encoder.sv
// Randomized and directed bench for scan_priority_encoder: three instances
// (16-bit LSB-first, 16-bit MSB-first, 5-bit LSB-first) against a set-bit queue model.
module tb_scan_priority_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] t_vec [3];
    logic        t_ivld [3];
    logic        t_ordy [3];

    logic        w_ir [3];
    logic        w_ov [3];
    logic        w_last [3];
    logic        w_none [3];
    logic [3:0]  w_idx [3];
    logic [4:0]  w_cnt [3];

    logic        ir0, ov0, last0, none0, ir1, ov1, last1, none1, ir2, ov2, last2, none2;
    logic [3:0]  idx0, idx1;
    logic [2:0]  idx2;
    logic [4:0]  cnt0, cnt1;
    logic [2:0]  cnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scan_priority_encoder #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_vec(t_vec[0]), .in_valid(t_ivld[0]), .in_ready(ir0),
        .out_idx(idx0), .out_valid(ov0), .out_ready(t_ordy[0]), .out_last(last0),
        .out_none(none0), .out_count(cnt0));

    scan_priority_encoder #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_vec(t_vec[1]), .in_valid(t_ivld[1]), .in_ready(ir1),
        .out_idx(idx1), .out_valid(ov1), .out_ready(t_ordy[1]), .out_last(last1),
        .out_none(none1), .out_count(cnt1));

    scan_priority_encoder #(.WIDTH(5), .MSB_FIRST(1'b0)) u_w5 (
        .clk(clk), .rst(rst), .in_vec(t_vec[2][4:0]), .in_valid(t_ivld[2]), .in_ready(ir2),
        .out_idx(idx2), .out_valid(ov2), .out_ready(t_ordy[2]), .out_last(last2),
        .out_none(none2), .out_count(cnt2));

    assign w_ir[0] = ir0;   assign w_ir[1] = ir1;   assign w_ir[2] = ir2;
    assign w_ov[0] = ov0;   assign w_ov[1] = ov1;   assign w_ov[2] = ov2;
    assign w_last[0] = last0; assign w_last[1] = last1; assign w_last[2] = last2;
    assign w_none[0] = none0; assign w_none[1] = none1; assign w_none[2] = none2;
    assign w_idx[0] = idx0; assign w_idx[1] = idx1; assign w_idx[2] = {1'b0, idx2};
    assign w_cnt[0] = cnt0; assign w_cnt[1] = cnt1; assign w_cnt[2] = {2'b00, cnt2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: expected beats are the set-bit indices in emission order (or one 0 for an empty vector).
    task automatic run_vec(input int d, input logic [15:0] v, input int width, input bit msb,
                           input int rdy_pct, input int stall, input bit pulse);
        int exp_q[$];
        int k;
        int cyc;
        int stalls_left;
        int wait_c;
        bit all_rdy;
        bit rdy;
        bit zero;
        k = 0;
        for (int i = 0; i < width; i++) begin
            if (v[i]) begin
                k++;
                if (msb) exp_q.push_front(i);
                else     exp_q.push_back(i);
            end
        end
        zero = (k == 0);
        if (zero) exp_q.push_back(0);

        wait_c = 0;
        while (!w_ir[d] && wait_c < 50) begin
            @(negedge clk);
            wait_c++;
        end
        chk("in_ready_wait", 32'(w_ir[d]), 32'd1);
        t_vec[d]  = v;
        t_ivld[d] = 1'b1;
        t_ordy[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        t_ivld[d] = 1'b0;
        cyc = 1;
        stalls_left = stall;
        all_rdy = 1'b1;
        while (exp_q.size() > 0 && cyc < 400) begin
            chk("out_valid", 32'(w_ov[d]), 32'd1);
            chk("out_idx", 32'(w_idx[d]), 32'(exp_q[0]));
            chk("out_last", 32'(w_last[d]), 32'(exp_q.size() == 1));
            chk("out_none", 32'(w_none[d]), 32'(zero));
            chk("out_count", 32'(w_cnt[d]), 32'(k));
            if (stalls_left > 0) begin
                rdy = 1'b0;
                stalls_left--;
            end else begin
                rdy = ($urandom_range(99) < rdy_pct);
            end
            if (!rdy) all_rdy = 1'b0;
            t_ordy[d] = rdy;
            if (pulse && !(rdy && exp_q.size() == 1)) begin
                t_ivld[d] = 1'($urandom_range(1));
                t_vec[d]  = 16'($urandom);
            end else begin
                t_ivld[d] = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (rdy) void'(exp_q.pop_front());
        end
        t_ordy[d] = 1'b0;
        t_ivld[d] = 1'b0;
        chk("beats_remaining", 32'(exp_q.size()), 32'd0);
        chk("idle_out_valid", 32'(w_ov[d]), 32'd0);
        chk("idle_in_ready", 32'(w_ir[d]), 32'd1);
        if (all_rdy) chk("ready_latency", 32'(cyc), 32'((k == 0) ? 2 : k + 1));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            t_vec[i]  = 16'h0000;
            t_ivld[i] = 1'b0;
            t_ordy[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", 32'(w_ov[i]), 32'd0);
            chk("rst_out_idx", 32'(w_idx[i]), 32'd0);
            chk("rst_out_count", 32'(w_cnt[i]), 32'd0);
            chk("rst_out_last", 32'(w_last[i]), 32'd0);
            chk("rst_out_none", 32'(w_none[i]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", 32'(w_ir[0]), 32'd1);

        // out_ready while idle must not start anything
        for (int i = 0; i < 3; i++) t_ordy[i] = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_ordy_valid", 32'(w_ov[0]), 32'd0);
        end
        for (int i = 0; i < 3; i++) t_ordy[i] = 1'b0;

        // directed scenarios
        run_vec(0, 16'h8421, 16, 1'b0, 100, 0, 1'b0);
        run_vec(1, 16'h0006, 16, 1'b1, 100, 0, 1'b0);
        run_vec(0, 16'h0000, 16, 1'b0, 100, 0, 1'b0);
        run_vec(0, 16'h0030, 16, 1'b0, 100, 3, 1'b1);
        run_vec(0, 16'hFFFF, 16, 1'b0, 100, 0, 1'b0);
        run_vec(1, 16'hFFFF, 16, 1'b1, 60, 2, 1'b1);
        run_vec(2, 16'h001F, 5, 1'b0, 100, 0, 1'b0);

        // reset mid-emission, with a simultaneous capture attempt on an idle instance
        t_vec[0]  = 16'hFFFF;
        t_ivld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_ivld[0] = 1'b0;
        t_ordy[0] = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst_idx", 32'(w_idx[0]), 32'd3);
        rst       = 1'b1;
        t_vec[1]  = 16'h00F0;
        t_ivld[1] = 1'b1;
        t_ordy[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(w_ov[0]), 32'd0);
        chk("mid_rst_out_count", 32'(w_cnt[0]), 32'd0);
        chk("rst_prio_no_capture", 32'(w_ov[1]), 32'd0);
        rst       = 1'b0;
        t_ivld[1] = 1'b0;
        t_ordy[0] = 1'b0;
        t_ordy[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("after_rst_in_ready", 32'(w_ir[0]), 32'd1);
        chk("after_rst_out_valid", 32'(w_ov[1]), 32'd0);
        run_vec(0, 16'h0001, 16, 1'b0, 100, 0, 1'b0);

        // random traffic
        for (int n = 0; n < 150; n++) begin
            run_vec(2, 16'($urandom_range(31)), 5, 1'b0, 70, 0, 1'($urandom_range(1)));
        end
        for (int n = 0; n < 30; n++) begin
            run_vec(1, 16'($urandom), 16, 1'b1, 75, 0, 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scan_priority_encoder.md
SCAN_PRIORITY_ENCODER -- requirements
Module: scan_priority_encoder

Interface
REQ-001 Parameter WIDTH, default 16, is the request vector width; legal range 2..256.
REQ-002 Parameter MSB_FIRST, default 0: 0 emits indices lowest-first, 1 emits highest-first.
REQ-003 Derived IDX_W = clog2(WIDTH) and CNT_W = clog2(WIDTH+1) SHALL be localparams, not user-settable.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_vec  input  WIDTH  request vector; bit i set means index i is hit.
REQ-007 in_valid  input  1  in_vec is presented.
REQ-008 in_ready  output  1  block can accept a vector this cycle.
REQ-009 out_idx  output  IDX_W  binary index of the current hit.
REQ-010 out_valid  output  1  out_idx/out_last/out_none/out_count are valid.
REQ-011 out_ready  input  1  consumer accepts the current beat.
REQ-012 out_last  output  1  current beat is the final beat for the captured vector.
REQ-013 out_none  output  1  captured vector was all-zero.
REQ-014 out_count  output  CNT_W  population count of the captured vector, constant across all beats of that vector.

Function
REQ-015 Two states SHALL exist: IDLE (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-016 Input handshake: in_valid & in_ready in IDLE captures in_vec into a pending register and enters EMIT on the next edge.
REQ-017 Output latency: first beat SHALL be visible with out_valid=1 exactly one cycle after input acceptance.
REQ-018 Each beat: out_idx = index of lowest set pending bit (MSB_FIRST=0) or highest set pending bit (MSB_FIRST=1).
REQ-019 Beat sequencing: out_valid & out_ready clears the emitted bit from pending; the next beat appears the following cycle with no bubble.
REQ-020 out_last SHALL be 1 exactly when pending holds one set bit.
REQ-021 Return to IDLE: acceptance of the out_last beat returns to IDLE; in_ready=1 on the next cycle.
REQ-022 Backpressure: while out_valid=1 and out_ready=0, out_idx, out_last, out_none and out_count SHALL hold stable.
REQ-023 All-zero capture: in_vec=0 SHALL produce exactly one beat with out_none=1, out_last=1, out_idx=0, out_count=0.
REQ-024 Nonzero vectors: out_none=0 on every beat.
REQ-025 Beat count: a vector with k set bits SHALL produce exactly max(k,1) beats; out_count=k on each.
REQ-026 in_valid in EMIT SHALL be ignored; no capture and no state change; the producer holds its data until in_ready.
REQ-027 All-ones vector: 0xFFFF (WIDTH=16) SHALL produce 16 beats, out_count=16 (CNT_W=5), no truncation.
REQ-028 All outputs SHALL be driven from registers or from the state register only; no combinational path from in_vec to any output.
REQ-029 out_ready in IDLE SHALL have no effect.

Reset
REQ-030 rst=1 at a clock edge: state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, out_none=0, out_count=0; in_ready=1 from the first cycle after reset deasserts.
REQ-031 Reset mid-EMIT SHALL discard all remaining beats.
REQ-032 Reset has priority over simultaneous in_valid or out_ready; no capture occurs in a reset cycle.

Verification (WIDTH=16 unless stated)
REQ-033 Scenario, LSB-first: MSB_FIRST=0, in_vec=0x8421, out_ready=1 -> beats idx 0,5,10,15; out_last only on 15; out_count=4 each; in_ready high again 5 cycles after acceptance.
REQ-034 Scenario, MSB-first: MSB_FIRST=1, in_vec=0x0006 -> beats idx 2 then 1; out_last on idx 1; out_count=2.
REQ-035 Scenario, zero vector: in_vec=0x0000 -> one beat, out_none=1, out_last=1, out_idx=0, out_count=0.
REQ-036 Scenario, backpressure: in_vec=0x0030, out_ready low 3 cycles then high -> idx 4 held 4 cycles, then idx 5 with out_last; in_valid pulsed during EMIT is not captured.
REQ-037 Scenario, reset mid-operation: in_vec=0xFFFF, rst asserted after 3 accepted beats -> out_valid=0 next cycle, in_ready=1 after release; new vector 0x0001 -> single beat idx 0.
REQ-038 Scenario, random: WIDTH=5, random vectors with random out_ready -> beat sequence matches a set-bit scoreboard, counts match popcount.
